// File: rtl/reg_dump_pkg.sv
// ============================================================================
// Module : reg_dump_pkg
// Brief  : Shared types and constants for the register dump reader.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package reg_dump_pkg;

    localparam int REG_AW       = 5;
    localparam int DEF_NUM_REGS = 32;
    localparam int DEF_DATA_W   = 32;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_READ = 3'd1,
        ST_SEND = 3'd2,
        ST_CSUM = 3'd3,
        ST_DONE = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/reg_dump_csum.sv
// ============================================================================
// Module : reg_dump_csum
// Brief  : XOR accumulator with synchronous clear and enable.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module reg_dump_csum #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              en,
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] acc
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc ^ data;
        end
    end

endmodule

`default_nettype wire

// File: rtl/reg_dump_reader.sv
// ============================================================================
// Module : reg_dump_reader
// Brief  : Streams a (possibly wrapping) range of register-file entries out as
//          valid/ready beats. Define REG_DUMP_CHECKSUM_EN to append an XOR
//          checksum beat after the last data word.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module reg_dump_reader
    import reg_dump_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int DATA_W   = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [4:0]        first_reg,
    input  logic [4:0]        last_reg,
    output logic [4:0]        rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [4:0]        out_idx,
    output logic              out_last,
    output logic              out_csum,
    output logic              busy,
    output logic              done
);

    state_t            state;
    logic [REG_AW-1:0] idx;
    logic [REG_AW-1:0] end_idx;
    logic              accept;
    logic              idx_at_end;
    logic [REG_AW-1:0] idx_next;

    assign accept     = out_valid && out_ready;
    assign idx_at_end = (idx == end_idx);
    assign idx_next   = (idx == REG_AW'(NUM_REGS - 1)) ? '0 : idx + 1'b1;
    assign rd_addr    = idx;
    assign busy       = (state != ST_IDLE);

`ifdef REG_DUMP_CHECKSUM_EN
    logic [DATA_W-1:0] csum_acc;
    logic              csum_clear;
    logic              csum_en;

    assign csum_clear = (state == ST_IDLE) && start;
    assign csum_en    = (state == ST_SEND) && accept;

    reg_dump_csum #(
        .DATA_W (DATA_W)
    ) u_csum (
        .clk   (clk),
        .rst   (rst),
        .clear (csum_clear),
        .en    (csum_en),
        .data  (out_data),
        .acc   (csum_acc)
    );
`else
    assign out_csum = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            idx       <= '0;
            end_idx   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
            done      <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
            out_csum  <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        idx     <= first_reg;
                        end_idx <= last_reg;
                        state   <= ST_READ;
                    end
                end

                ST_READ: begin
                    out_data  <= rd_data;
                    out_idx   <= idx;
                    out_valid <= 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
                    out_last  <= 1'b0;
`else
                    out_last  <= idx_at_end;
`endif
                    state     <= ST_SEND;
                end

                ST_SEND: begin
                    if (accept) begin
                        if (idx_at_end) begin
`ifdef REG_DUMP_CHECKSUM_EN
                            // Accumulator updates on this same edge, so fold in the final word here.
                            out_data  <= csum_acc ^ out_data;
                            out_idx   <= '0;
                            out_csum  <= 1'b1;
                            out_last  <= 1'b1;
                            state     <= ST_CSUM;
`else
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            done      <= 1'b1;
                            state     <= ST_DONE;
`endif
                        end else begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            idx       <= idx_next;
                            state     <= ST_READ;
                        end
                    end
                end

`ifdef REG_DUMP_CHECKSUM_EN
                ST_CSUM: begin
                    if (accept) begin
                        out_valid <= 1'b0;
                        out_csum  <= 1'b0;
                        out_last  <= 1'b0;
                        done      <= 1'b1;
                        state     <= ST_DONE;
                    end
                end
`endif

                ST_DONE: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/reg_dump_reader.md
REG_DUMP_READER -- requirements
Module: reg_dump_reader

Interface
REQ-001 SHALL have parameter NUM_REGS, default 32, number of register-file entries addressed.
REQ-002 SHALL have parameter DATA_W, default 32, register data width.
REQ-003 SHALL use one clock; reset is asynchronous and active-high. Ports are named clk and rst.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 start  input  1  request a dump; sampled only in IDLE.
REQ-007 first_reg  input  5  first register index of the dump, sampled with start.
REQ-008 last_reg  input  5  last register index of the dump (inclusive), sampled with start.
REQ-009 rd_addr  output  5  read address driven to the register-file async read port.
REQ-010 rd_data  input  DATA_W  async read data returned for rd_addr.
REQ-011 out_valid  output  1  output beat valid.
REQ-012 out_ready  input  1  consumer accepts the beat.
REQ-013 out_data  output  DATA_W  beat payload.
REQ-014 out_idx  output  5  register index of the beat.
REQ-015 out_last  output  1  final beat of the dump.
REQ-016 out_csum  output  1  beat is the checksum beat.
REQ-017 busy  output  1  high in every state except IDLE.
REQ-018 done  output  1  single-cycle pulse when the dump completes.

Function
REQ-019 SHALL implement FSM states IDLE, READ, SEND, CSUM, DONE.
REQ-020 IDLE->READ when start=1: latch idx<=first_reg and end<=last_reg.
REQ-021 READ: rd_addr=idx. Capture rd_data into out_data and idx into out_idx at the clock edge. Go to SEND.
REQ-022 SEND: out_valid=1. out_data, out_idx and out_last SHALL stay stable until out_valid&&out_ready.
REQ-023 On SEND acceptance:
- if idx==end: go to CSUM (macro defined) or DONE;
- else: idx<=idx+1 modulo 32 and go to READ.
REQ-024 Range SHALL wrap: first_reg>last_reg dumps first..31 then 0..last. first_reg==last_reg dumps exactly one word.
REQ-025 Latency: start sampled at edge N. First out_valid SHALL be asserted in the cycle after edge N+1. Peak throughput is one beat per 2 cycles.
REQ-026 DONE: done=1 for exactly one cycle, then IDLE.
REQ-027 start SHALL be ignored while busy=1.
REQ-028 Each word SHALL reflect register contents at its READ cycle. Writes made after capture are not reflected.
REQ-029 out_last SHALL be 1 only on the final beat of the dump.
REQ-030 rd_addr SHALL equal idx in all states.

Reset
REQ-031 rst SHALL immediately force, regardless of clk:
- state=IDLE;
- idx=0 and rd_addr=0;
- out_valid, out_last, out_csum, busy and done =0;
- out_data=0 and out_idx=0.
REQ-032 Reset mid-dump SHALL abandon the dump with no done pulse. A new start after rst deassertion SHALL behave normally.

Configuration
REQ-033 Macro REG_DUMP_CHECKSUM_EN defined:
- the FSM SHALL XOR-accumulate every accepted data word;
- after the last data word, CSUM SHALL present one beat with out_data=XOR, out_idx=0, out_csum=1, out_last=1;
- the data beat before it SHALL have out_last=0;
- the accumulator SHALL clear on start.
REQ-034 Macro undefined: CSUM is unreachable, out_csum is tied 0, and the last data beat carries out_last=1.

Structure
REQ-035 Shared package reg_dump_pkg SHALL hold the FSM state typedef/encoding, the REG_AW=5 constant, and the NUM_REGS/DATA_W defaults.
REQ-036 One sub-module, reg_dump_csum (XOR accumulator with clear/enable), SHALL be instantiated only under REG_DUMP_CHECKSUM_EN. All other logic SHALL be inline.

Verification
REQ-037 Preload reg[i]=i*3, start with first=2, last=4, out_ready=1 -> beats (2,6),(4,12) stop; corrected: (2,6),(3,9),(4,12), last on idx 4, done one cycle later.
REQ-038 Wrap dump with first=30, last=1 -> idx order 30,31,0,1, 4 beats, out_last on idx 1.
REQ-039 out_ready held 0 for 5 cycles during SEND -> out_valid and payload stable for all 5 cycles, no idx advance.
REQ-040 Assert rst during the 2nd beat -> outputs zero immediately, no done. A subsequent start with first=last=7 gives a single beat with out_last=1.
REQ-041 With REG_DUMP_CHECKSUM_EN, dump of regs 0..31 with reg[i]=1<<i -> 33 beats, final beat out_csum=1, out_data=32'hFFFFFFFF.
REQ-042 Pulse start while busy -> ignored. The in-progress dump's beat count and order are unchanged.
